// File: rtl/aftab_immencoder.sv
// Debugger instruction builder: scatters an immediate into RISC-V I/S/B/U/J fields, or expands LI into ADDI / LUI+ADDI.
// Latency: one cycle from request acceptance to the first valid word; an unencodable immediate gives a one-cycle immError pulse instead.
// Backpressure: reqReady is high only when idle; each word is held stable until instReady takes it.
module aftab_immencoder #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reqValid,
  output logic            reqReady,
  input  logic [2:0]      fmt,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [size-1:0] imm,
  output logic            instValid,
  input  logic            instReady,
  output logic [size-1:0] inst,
  output logic            instLast,
  output logic            immError
);

  localparam logic [2:0] FMT_I  = 3'd0;
  localparam logic [2:0] FMT_S  = 3'd1;
  localparam logic [2:0] FMT_B  = 3'd2;
  localparam logic [2:0] FMT_U  = 3'd3;
  localparam logic [2:0] FMT_J  = 3'd4;
  localparam logic [2:0] FMT_LI = 3'd5;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} stateT;

  stateT       state;
  logic        legal;
  logic        twoWord;
  logic        twoWordQ;
  logic        fits12;
  logic        fitsB;
  logic        fitsJ;
  logic [19:0] liHi;
  logic [31:0] word1;
  logic [31:0] word2;
  logic [31:0] word2Q;
  logic        xfer;

  // funct7 is a reserved input that no supported format places in the word.
  logic unusedFunct7;
  assign unusedFunct7 = ^funct7;

  assign reqReady = (state == IDLE);
  assign xfer     = instValid & instReady;

  // Range checks and word assembly for the request currently on the inputs.
  always_comb begin
    fits12  = (imm[31:11] == '0) || (&imm[31:11]);
    fitsB   = (imm[31:12] == '0) || (&imm[31:12]);
    fitsJ   = (imm[31:20] == '0) || (&imm[31:20]);
    // ADDI sign-extends its 12 bits, so round the upper part up when imm[11] is set.
    liHi    = imm[31:12] + {19'd0, imm[11]};
    legal   = 1'b0;
    twoWord = 1'b0;
    word1   = '0;
    word2   = '0;
    case (fmt)
      FMT_I: begin
        legal = fits12;
        word1 = {imm[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: begin
        legal = fits12;
        word1 = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      FMT_B: begin
        legal = fitsB & ~imm[0];
        word1 = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      FMT_U: begin
        legal = (imm[11:0] == '0);
        word1 = {imm[31:12], rd, opcode};
      end
      FMT_J: begin
        legal = fitsJ & ~imm[0];
        word1 = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      end
      FMT_LI: begin
        legal = 1'b1;
        if (fits12) begin
          word1 = {imm[11:0], 5'd0, 3'b000, rd, OPC_OPIMM};
        end else begin
          twoWord = 1'b1;
          word1   = {liHi, rd, OPC_LUI};
          word2   = {imm[11:0], rd, 3'b000, rd, OPC_OPIMM};
        end
      end
      default: legal = 1'b0;
    endcase
  end

  // Request/emit sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      instValid <= 1'b0;
      inst      <= '0;
      instLast  <= 1'b0;
      immError  <= 1'b0;
      word2Q    <= '0;
      twoWordQ  <= 1'b0;
    end else begin
      immError <= 1'b0;
      case (state)
        IDLE: begin
          if (reqValid) begin
            if (legal) begin
              state     <= EMIT1;
              instValid <= 1'b1;
              inst      <= word1;
              instLast  <= ~twoWord;
              word2Q    <= word2;
              twoWordQ  <= twoWord;
            end else begin
              immError <= 1'b1;
            end
          end
        end
        EMIT1: begin
          if (xfer) begin
            if (twoWordQ) begin
              state    <= EMIT2;
              inst     <= word2Q;
              instLast <= 1'b1;
            end else begin
              state     <= IDLE;
              instValid <= 1'b0;
              instLast  <= 1'b0;
            end
          end
        end
        EMIT2: begin
          if (xfer) begin
            state     <= IDLE;
            instValid <= 1'b0;
            instLast  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          instValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aftab_immencoder.sv
// Bench for aftab_immencoder: directed encodings, stalls, boundaries, reset abort and random round-trip.
// Expected values come from constants, a range-rule legality model and a reference immediate decoder.
// Inputs are driven just after rising edges; outputs are sampled 1 ns after rising edges.
module tb_aftab_immencoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] imm = '0;
  logic        instValid;
  logic        instReady = 1'b0;
  logic [31:0] inst;
  logic        instLast;
  logic        immError;

  int nCompared = 0;
  int nMismatched = 0;

  aftab_immencoder #(.size(32)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .instValid(instValid), .instReady(instReady), .inst(inst),
    .instLast(instLast), .immError(immError)
  );

  always #5 clk = ~clk;

  // Datapath immediate generator: recovers the immediate from an encoded word.
  function automatic int immGen(input int f, input logic [31:0] w);
    case (f)
      0: return int'({{20{w[31]}}, w[31:20]});
      1: return int'({{20{w[31]}}, w[31:25], w[11:7]});
      2: return int'({{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0});
      3: return int'({w[31:12], 12'd0});
      4: return int'({{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0});
      default: return 0;
    endcase
  endfunction

  // Encodability rules as signed ranges and alignment.
  function automatic bit isLegal(input int f, input int v);
    case (f)
      0, 1: return (v >= -2048) && (v <= 2047);
      2: return ((v & 1) == 0) && (v >= -4096) && (v <= 4094);
      3: return (v & 32'hFFF) == 0;
      4: return ((v & 1) == 0) && (v >= -(1 << 20)) && (v <= (1 << 20) - 2);
      5: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic setReq(input int f, input int op, input int f3, input int rdV,
                        input int r1, input int r2, input int v);
    fmt = f[2:0]; opcode = op[6:0]; funct3 = f3[2:0]; funct7 = 7'($urandom_range(0, 127));
    rd = rdV[4:0]; rs1 = r1[4:0]; rs2 = r2[4:0]; imm = v;
  endtask

  // Present the request until accepted (bounded); returns 1 ns after the accepting edge.
  task automatic sendReq(output bit ok);
    ok = 1'b0;
    reqValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (reqReady) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    reqValid = 1'b0;
  endtask

  // Wait (bounded) for a word and take it with a one-cycle instReady.
  task automatic getWord(output logic [31:0] w, output logic l, output bit ok);
    ok = 1'b0; w = '0; l = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instValid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      w = inst; l = instLast;
      instReady = 1'b1;
      @(posedge clk); #1;
      instReady = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2;
    nCompared++;
    if ({reqReady, instValid, instLast, immError, inst} !== {4'b1000, 32'h0}) begin
      nMismatched++;
      $display("FAIL reset_state: got rdy=%b vld=%b last=%b err=%b inst=%h required 1 0 0 0 00000000",
               reqReady, instValid, instLast, immError, inst);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_itype();
    bit ok; logic [31:0] w; logic l;
    setReq(0, 'h13, 0, 5, 6, 0, -1);
    sendReq(ok);
    nCompared++;
    if (!ok || {instValid, instLast, inst} !== {2'b11, 32'hFFF30293}) begin
      nMismatched++;
      $display("FAIL itype_latency1: got acc=%b vld=%b last=%b inst=%h required 1 1 1 fff30293", ok, instValid, instLast, inst);
    end
    getWord(w, l, ok);
    nCompared++;
    if ({instValid, reqReady} !== 2'b01) begin
      nMismatched++;
      $display("FAIL itype_after: got vld=%b rdy=%b required 0 1", instValid, reqReady);
    end
  endtask

  task automatic test_btype();
    bit ok; logic [31:0] w; logic l;
    setReq(2, 'h63, 0, 0, 1, 2, -4);
    sendReq(ok);
    getWord(w, l, ok);
    nCompared++;
    if (!ok || {w, l} !== {32'hFE208EE3, 1'b1}) begin
      nMismatched++;
      $display("FAIL btype_inst: got ok=%b inst=%h last=%b required fe208ee3 1", ok, w, l);
    end
    @(posedge clk); #1;
    setReq(2, 'h63, 0, 0, 1, 2, 3);
    sendReq(ok);
    nCompared++;
    if (!ok || {immError, instValid, reqReady} !== 3'b101) begin
      nMismatched++;
      $display("FAIL btype_odd_err: got acc=%b err=%b vld=%b rdy=%b required 1 1 0 1", ok, immError, instValid, reqReady);
    end
    @(posedge clk); #1;
    nCompared++;
    if ({immError, instValid} !== 2'b00) begin
      nMismatched++;
      $display("FAIL btype_err_pulse: got err=%b vld=%b required 0 0", immError, instValid);
    end
  endtask

  task automatic test_li_stall();
    bit ok; bit stable;
    logic [31:0] expW [2];
    logic        expL [2];
    expW[0] = 32'h12346537; expL[0] = 1'b0;
    expW[1] = 32'hFFF50513; expL[1] = 1'b1;
    setReq(5, 0, 0, 10, 0, 0, 32'h12345FFF);
    sendReq(ok);
    for (int k = 0; k < 2; k++) begin
      stable = 1'b1;
      for (int c = 0; c < 3; c++) begin
        if (!(instValid === 1'b1 && inst === expW[k] && instLast === expL[k])) stable = 1'b0;
        @(posedge clk); #1;
      end
      nCompared++;
      if (!stable || {instValid, inst, instLast} !== {1'b1, expW[k], expL[k]}) begin
        nMismatched++;
        $display("FAIL li_stall_word%0d: got stable=%b vld=%b inst=%h last=%b required 1 1 %h %b",
                 k, stable, instValid, inst, instLast, expW[k], expL[k]);
      end
      instReady = 1'b1;
      @(posedge clk); #1;
      instReady = 1'b0;
    end
    nCompared++;
    if ({instValid, reqReady} !== 2'b01) begin
      nMismatched++;
      $display("FAIL li_stall_end: got vld=%b rdy=%b required 0 1", instValid, reqReady);
    end
  endtask

  task automatic test_li_small_and_wrap();
    bit ok; logic [31:0] w; logic l;
    setReq(5, 0, 0, 1, 0, 0, 100);
    sendReq(ok);
    getWord(w, l, ok);
    nCompared++;
    if (!ok || {w, l, instValid} !== {32'h06400093, 2'b10}) begin
      nMismatched++;
      $display("FAIL li_small: got ok=%b inst=%h last=%b vld_after=%b required 06400093 1 0", ok, w, l, instValid);
    end
    @(posedge clk); #1;
    setReq(5, 0, 0, 1, 0, 0, 32'h7FFFF800);
    sendReq(ok);
    getWord(w, l, ok);
    nCompared++;
    if (!ok || {w, l} !== {32'h800000B7, 1'b0}) begin
      nMismatched++;
      $display("FAIL li_wrap_lui: got ok=%b inst=%h last=%b required 800000b7 0", ok, w, l);
    end
    getWord(w, l, ok);
    nCompared++;
    if (!ok || {w, l} !== {32'h80008093, 1'b1}) begin
      nMismatched++;
      $display("FAIL li_wrap_addi: got ok=%b inst=%h last=%b required 80008093 1", ok, w, l);
    end
  endtask

  task automatic test_jtype();
    bit ok; logic [31:0] w; logic l;
    @(posedge clk); #1;
    setReq(4, 'h6F, 0, 1, 0, 0, 32'h800);
    sendReq(ok);
    getWord(w, l, ok);
    nCompared++;
    if (!ok || {w, l} !== {32'h001000EF, 1'b1}) begin
      nMismatched++;
      $display("FAIL jtype_inst: got ok=%b inst=%h last=%b required 001000ef 1", ok, w, l);
    end
  endtask

  // A request raised during the final transfer must wait for IDLE.
  task automatic test_back_to_back();
    bit ok; logic [31:0] w; logic l;
    @(posedge clk); #1;
    setReq(0, 'h13, 0, 3, 4, 0, 7);
    sendReq(ok);
    setReq(1, 'h23, 2, 0, 8, 9, -2048);
    reqValid = 1'b1; instReady = 1'b1;
    nCompared++;
    if (reqReady !== 1'b0) begin
      nMismatched++;
      $display("FAIL b2b_busy_ready: got %b required 0", reqReady);
    end
    @(posedge clk); #1;
    instReady = 1'b0;
    nCompared++;
    if ({instValid, reqReady} !== 2'b01) begin
      nMismatched++;
      $display("FAIL b2b_gap: got vld=%b rdy=%b required 0 1", instValid, reqReady);
    end
    @(posedge clk); #1;
    reqValid = 1'b0;
    getWord(w, l, ok);
    nCompared++;
    if (!ok || immGen(1, w) != -2048 || w[6:0] !== 7'h23 || w[14:12] !== 3'd2 || w[19:15] !== 5'd8 || w[24:20] !== 5'd9) begin
      nMismatched++;
      $display("FAIL b2b_second: got ok=%b inst=%h required S-type imm=-2048 rs1=8 rs2=9 f3=2 op=23", ok, w);
    end
  endtask

  task automatic test_boundaries();
    int bf [14] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 4, 4, 4, 6, 7};
    int bv [14] = '{2047, 2048, -2048, -2049, 2047, -2049, 4094, 4096, -4096, (1 << 20) - 2, 1 << 20, -(1 << 20), 0, 0};
    bit ok; bit exp; bit got; logic [31:0] w; logic l;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      setReq(bf[i], $urandom_range(0, 127), 0, 1, 2, 3, bv[i]);
      sendReq(ok);
      exp = isLegal(bf[i], bv[i]);
      got = instValid && !immError;
      nCompared++;
      if (!ok || got !== exp || (instValid == immError)) begin
        nMismatched++;
        $display("FAIL boundary fmt=%0d imm=%0d: got acc=%b vld=%b err=%b required legal=%b",
                 bf[i], bv[i], ok, instValid, immError, exp);
      end
      if (instValid) getWord(w, l, ok);
    end
  endtask

  task automatic test_random_roundtrip();
    bit ok; bit fieldsOk; logic [31:0] w1, w2; logic l1, l2;
    int f, v, op, rdV, r1, r2, f3, dec;
    for (int n = 0; n < 1000; n++) begin
      f = $urandom_range(0, 5);
      op = $urandom_range(0, 127); f3 = $urandom_range(0, 7);
      rdV = $urandom_range(0, 31); r1 = $urandom_range(0, 31); r2 = $urandom_range(0, 31);
      case (f)
        0, 1: v = int'($urandom_range(0, 4095)) - 2048;
        2: v = (int'($urandom_range(0, 4095)) - 2048) * 2;
        3: v = int'($urandom & 32'hFFFFF000);
        4: v = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
        default: v = $urandom_range(0, 1) ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom);
      endcase
      @(posedge clk); #1;
      setReq(f, op, f3, rdV, r1, r2, v);
      sendReq(ok);
      getWord(w1, l1, ok);
      fieldsOk = ok;
      w2 = '0; l2 = 1'b0;
      if (f != 5) begin
        dec = immGen(f, w1);
        if (w1[6:0] !== op[6:0] || l1 !== 1'b1) fieldsOk = 1'b0;
        if ((f == 0 || f == 3 || f == 4) && w1[11:7] !== rdV[4:0]) fieldsOk = 1'b0;
        if (f <= 2 && (w1[19:15] !== r1[4:0] || w1[14:12] !== f3[2:0])) fieldsOk = 1'b0;
        if ((f == 1 || f == 2) && w1[24:20] !== r2[4:0]) fieldsOk = 1'b0;
      end else if (v >= -2048 && v <= 2047) begin
        dec = immGen(0, w1);
        if (w1[6:0] !== 7'h13 || w1[19:12] !== 8'd0 || w1[11:7] !== rdV[4:0] || l1 !== 1'b1) fieldsOk = 1'b0;
      end else begin
        getWord(w2, l2, ok);
        if (!ok) fieldsOk = 1'b0;
        dec = immGen(3, w1) + immGen(0, w2);
        if (w1[6:0] !== 7'h37 || w1[11:7] !== rdV[4:0] || l1 !== 1'b0) fieldsOk = 1'b0;
        if (w2[6:0] !== 7'h13 || w2[11:7] !== rdV[4:0] || w2[19:15] !== rdV[4:0] || w2[14:12] !== 3'd0 || l2 !== 1'b1) fieldsOk = 1'b0;
      end
      nCompared++;
      if (dec != v || !fieldsOk) begin
        nMismatched++;
        $display("FAIL roundtrip fmt=%0d imm=%h: got decoded=%h fields_ok=%b w1=%h w2=%h required decoded=%h fields_ok=1",
                 f, v, dec, fieldsOk, w1, w2, v);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; bit quiet; logic [31:0] w; logic l;
    @(posedge clk); #1;
    setReq(5, 0, 0, 10, 0, 0, 32'h12345FFF);
    sendReq(ok);
    getWord(w, l, ok);
    rst = 1'b0;
    #1;
    nCompared++;
    if ({reqReady, instValid, instLast, immError, inst} !== {4'b1000, 32'h0}) begin
      nMismatched++;
      $display("FAIL reset_mid_state: got rdy=%b vld=%b last=%b err=%b inst=%h required 1 0 0 0 00000000",
               reqReady, instValid, instLast, immError, inst);
    end
    @(negedge clk); rst = 1'b1;
    instReady = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (instValid !== 1'b0 || reqReady !== 1'b1) quiet = 1'b0;
    end
    instReady = 1'b0;
    nCompared++;
    if (!quiet) begin
      nMismatched++;
      $display("FAIL reset_mid_no_addi: got a word or busy state after release, required idle");
    end
  endtask

  initial begin
    test_reset();
    test_itype();
    test_btype();
    test_li_stall();
    test_li_small_and_wrap();
    test_jtype();
    test_back_to_back();
    test_boundaries();
    test_random_roundtrip();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
